// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg
//   Shared definitions for the 68000 bus-cycle master: FSM state encoding,
//   the captured-request record and the data value returned on error
//   completions.
package m68k_bus_pkg;

    // IDLE/ARMED are host-side states; S0..S7 track the 68000 half-clocks.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ARMED = 4'd1,
        ST_S0    = 4'd2,
        ST_S1    = 4'd3,
        ST_S2    = 4'd4,
        ST_S3    = 4'd5,
        ST_S4    = 4'd6,
        ST_S5    = 4'd7,
        ST_S6    = 4'd8,
        ST_S7    = 4'd9
    } bus_state_e;

    // Request fields latched at the handshake.
    typedef struct packed {
        logic        rw;     // 1 = read
        logic        uds;
        logic        lds;
        logic [22:0] addr;   // A23..A1
        logic [15:0] wdata;
    } bus_req_t;

    localparam logic [15:0] ERR_RDATA = 16'hFFFF;

endpackage

// File: rtl/m68k_bus_cycle.sv
// m68k_bus_cycle
//   Runs one 68000 asynchronous bus cycle (read or write) per host request,
//   stepping S0..S7 on the MCCLK edge pulses from ClockSync. A cycle with no
//   DTACK aborts after TIMEOUT_CYCLES falling edges in S4 and completes with
//   an error.
//
// Ports
//   SYSCLK, RESET               system clock, synchronous active-high reset
//   MCCLK_RISING/_FALLING       one-cycle pulses per 68000 clock edge
//   DTACK_LATCH/_AFTER_LATCH    DTACK sample point and the pulse 2 clk later
//   REQ_*                       host request (valid/ready handshake)
//   RESP_*                      one-cycle completion pulse, error, read data
//   BUS_*                       68000 address/data/strobe outputs, data input
module m68k_bus_cycle
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        MCCLK_RISING,
    input  logic        MCCLK_FALLING,
    input  logic        DTACK_LATCH,
    input  logic        DTACK_AFTER_LATCH,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_RW,
    input  logic        REQ_UDS,
    input  logic        REQ_LDS,
    input  logic [22:0] REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    output logic        RESP_VALID,
    output logic        RESP_ERR,
    output logic [15:0] RESP_RDATA,
    input  logic [15:0] BUS_DATA_IN,
    output logic [22:0] BUS_ADDR,
    output logic [15:0] BUS_DATA_OUT,
    output logic        BUS_DATA_OE,
    output logic        BUS_AS_n,
    output logic        BUS_UDS_n,
    output logic        BUS_LDS_n,
    output logic        BUS_RW
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    bus_state_e       state_q, state_d;
    bus_req_t         req_q, req_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q, err_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;
    logic [15:0]      rdata_q, rdata_d;
    logic [22:0]      addr_q, addr_d;
    logic [15:0]      dout_q, dout_d;
    logic             oe_q, oe_d;
    logic             as_n_q, as_n_d;
    logic             uds_n_q, uds_n_d;
    logic             lds_n_q, lds_n_d;
    logic             rw_q, rw_d;
    logic             handshake;

    assign handshake = REQ_VALID && ready_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            ready_q      <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            oe_q         <= 1'b0;
            as_n_q       <= 1'b1;
            uds_n_q      <= 1'b1;
            lds_n_q      <= 1'b1;
            rw_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            ready_q      <= ready_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            as_n_q       <= as_n_d;
            uds_n_q      <= uds_n_d;
            lds_n_q      <= lds_n_d;
            rw_q         <= rw_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        oe_d         = oe_q;
        as_n_d       = as_n_q;
        uds_n_d      = uds_n_q;
        lds_n_d      = lds_n_q;
        rw_d         = rw_q;
        // Ready drops on the handshake and is only re-raised from a settled
        // IDLE cycle, so the response cycle itself always sees ready low.
        ready_d      = (state_q == ST_IDLE) && !handshake;

        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    req_d = '{rw: REQ_RW, uds: REQ_UDS, lds: REQ_LDS,
                              addr: REQ_ADDR, wdata: REQ_WDATA};
                    err_d = 1'b0;
                    if (!REQ_UDS && !REQ_LDS) begin
                        // Nothing to transfer: answer with an error, no bus cycle.
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        rdata_d      = ERR_RDATA;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (MCCLK_RISING) begin
                    state_d = ST_S0;
                    addr_d  = req_q.addr;
                    rw_d    = req_q.rw;
                end
            end
            ST_S0: begin
                if (MCCLK_FALLING) state_d = ST_S1;
            end
            ST_S1: begin
                if (MCCLK_RISING) begin
                    state_d = ST_S2;
                    as_n_d  = 1'b0;
                    if (req_q.rw) begin
                        uds_n_d = !req_q.uds;
                        lds_n_d = !req_q.lds;
                    end else begin
                        rw_d = 1'b0;
                    end
                end
            end
            ST_S2: begin
                if (MCCLK_FALLING) begin
                    state_d = ST_S3;
                    if (!req_q.rw) begin
                        oe_d   = 1'b1;
                        dout_d = req_q.wdata;
                    end
                end
            end
            ST_S3: begin
                if (MCCLK_RISING) begin
                    state_d = ST_S4;
                    cnt_d   = '0;
                    // Write strobes follow the data by one half-clock.
                    if (!req_q.rw) begin
                        uds_n_d = !req_q.uds;
                        lds_n_d = !req_q.lds;
                    end
                end
            end
            ST_S4: begin
                // DTACK is checked first so it beats a coincident final timeout edge.
                if (DTACK_LATCH) begin
                    state_d = ST_S5;
                    if (req_q.rw) rdata_d = BUS_DATA_IN;
                end else if (MCCLK_FALLING) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        state_d = ST_S6;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_S5: begin
                if (DTACK_AFTER_LATCH) state_d = ST_S6;
            end
            ST_S6: begin
                if (MCCLK_FALLING) begin
                    state_d = ST_S7;
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                end
            end
            ST_S7: begin
                if (MCCLK_RISING) begin
                    state_d      = ST_IDLE;
                    oe_d         = 1'b0;
                    rw_d         = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    if (err_q) rdata_d = ERR_RDATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign REQ_READY    = ready_q;
    assign RESP_VALID   = resp_valid_q;
    assign RESP_ERR     = resp_err_q;
    assign RESP_RDATA   = rdata_q;
    assign BUS_ADDR     = addr_q;
    assign BUS_DATA_OUT = dout_q;
    assign BUS_DATA_OE  = oe_q;
    assign BUS_AS_n     = as_n_q;
    assign BUS_UDS_n    = uds_n_q;
    assign BUS_LDS_n    = lds_n_q;
    assign BUS_RW       = rw_q;

endmodule

// File: tb/tb_m68k_bus_cycle.sv
module tb_m68k_bus_cycle;

    logic        SYSCLK;
    logic        RESET;
    logic        MCCLK_RISING, MCCLK_FALLING, DTACK_LATCH, DTACK_AFTER_LATCH;
    logic        REQ_VALID, REQ_READY, REQ_RW, REQ_UDS, REQ_LDS;
    logic [22:0] REQ_ADDR;
    logic [15:0] REQ_WDATA;
    logic        RESP_VALID, RESP_ERR;
    logic [15:0] RESP_RDATA;
    logic [15:0] BUS_DATA_IN;
    logic [22:0] BUS_ADDR;
    logic [15:0] BUS_DATA_OUT;
    logic        BUS_DATA_OE, BUS_AS_n, BUS_UDS_n, BUS_LDS_n, BUS_RW;

    m68k_bus_cycle #(.TIMEOUT_CYCLES(4)) dut (
        .SYSCLK(SYSCLK), .RESET(RESET),
        .MCCLK_RISING(MCCLK_RISING), .MCCLK_FALLING(MCCLK_FALLING),
        .DTACK_LATCH(DTACK_LATCH), .DTACK_AFTER_LATCH(DTACK_AFTER_LATCH),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_RW(REQ_RW),
        .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .RESP_VALID(RESP_VALID), .RESP_ERR(RESP_ERR),
        .RESP_RDATA(RESP_RDATA), .BUS_DATA_IN(BUS_DATA_IN), .BUS_ADDR(BUS_ADDR),
        .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_DATA_OE(BUS_DATA_OE),
        .BUS_AS_n(BUS_AS_n), .BUS_UDS_n(BUS_UDS_n), .BUS_LDS_n(BUS_LDS_n),
        .BUS_RW(BUS_RW)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   resp_cnt = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic pulse(input bit r, input bit f, input bit dl, input bit da);
        MCCLK_RISING = r; MCCLK_FALLING = f; DTACK_LATCH = dl; DTACK_AFTER_LATCH = da;
        step();
        MCCLK_RISING = 0; MCCLK_FALLING = 0; DTACK_LATCH = 0; DTACK_AFTER_LATCH = 0;
    endtask

    task automatic rise(); pulse(1, 0, 0, 0); endtask
    task automatic fall(); pulse(0, 1, 0, 0); endtask

    task automatic expect_resp(input logic err, input logic [15:0] rdata, input logic chk_data);
        exp_t e;
        e.err = err; e.rdata = rdata; e.chk_data = chk_data;
        sb.push_back(e);
        exp_cnt++;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!REQ_READY && n < 20) begin
            step();
            n++;
        end
        if (!REQ_READY) chk("ready_wait_expired", 32'(REQ_READY), 32'd1);
    endtask

    task automatic do_req(input logic rw, input logic uds, input logic lds,
                          input logic [22:0] addr, input logic [15:0] wdata);
        wait_ready();
        REQ_VALID = 1; REQ_RW = rw; REQ_UDS = uds; REQ_LDS = lds;
        REQ_ADDR = addr; REQ_WDATA = wdata;
        step();
        REQ_VALID = 0;
        chk("ready_low_after_hs", 32'(REQ_READY), 32'd0);
    endtask

    // ARMED -> S0 -> S1 -> S2 -> S3 -> S4
    task automatic to_s4();
        rise(); fall(); rise(); fall(); rise();
    endtask

    // S4 -> S5 -> S6 -> S7 -> IDLE with DTACK presenting the given data
    task automatic finish_dtack(input logic [15:0] data);
        BUS_DATA_IN = data;
        pulse(0, 0, 1, 0);
        BUS_DATA_IN = 16'h0000;
        step();
        pulse(0, 0, 0, 1);
        fall();
        rise();
    endtask

    initial begin
        exp_t m;
        RESET = 1; REQ_VALID = 0; REQ_RW = 1; REQ_UDS = 0; REQ_LDS = 0;
        REQ_ADDR = '0; REQ_WDATA = '0; BUS_DATA_IN = '0;
        MCCLK_RISING = 0; MCCLK_FALLING = 0; DTACK_LATCH = 0; DTACK_AFTER_LATCH = 0;

        fork
            forever begin
                @(negedge SYSCLK);
                if (RESP_VALID === 1'b1) begin
                    resp_cnt++;
                    if (sb.size() == 0) begin
                        chk("resp_unexpected", 32'(RESP_VALID), 32'd0);
                    end else begin
                        m = sb.pop_front();
                        chk("resp_err", 32'(RESP_ERR), 32'(m.err));
                        if (m.chk_data) chk("resp_rdata", 32'(RESP_RDATA), 32'(m.rdata));
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) step();
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        chk("rst_resp_valid", 32'(RESP_VALID), 32'd0);
        chk("rst_resp_err", 32'(RESP_ERR), 32'd0);
        chk("rst_rdata", 32'(RESP_RDATA), 32'd0);
        chk("rst_strobes", 32'({BUS_AS_n, BUS_UDS_n, BUS_LDS_n, BUS_RW}), 32'hF);
        chk("rst_oe", 32'(BUS_DATA_OE), 32'd0);
        chk("rst_addr", 32'(BUS_ADDR), 32'd0);
        chk("rst_dout", 32'(BUS_DATA_OUT), 32'd0);
        RESET = 0;
        step(); step();
        chk("ready_after_release", 32'(REQ_READY), 32'd1);

        // Edges and DTACK pulses in IDLE are ignored
        rise(); fall(); pulse(0, 0, 1, 0); pulse(0, 0, 0, 1);
        chk("idle_as_n", 32'(BUS_AS_n), 32'd1);
        chk("idle_ready", 32'(REQ_READY), 32'd1);

        // Word read, 0x123456 >> 1, data 0xBEEF
        expect_resp(1'b0, 16'hBEEF, 1'b1);
        do_req(1'b1, 1'b1, 1'b1, 23'h091A2B, 16'h0000);
        rise();
        chk("rd_s0_addr", 32'(BUS_ADDR), 32'h091A2B);
        chk("rd_s0_as_n", 32'(BUS_AS_n), 32'd1);
        fall();
        chk("rd_s1_as_n", 32'(BUS_AS_n), 32'd1);
        rise();
        chk("rd_s2_strobes", 32'({BUS_AS_n, BUS_UDS_n, BUS_LDS_n, BUS_RW}), 32'h1);
        fall();
        chk("rd_s3_oe", 32'(BUS_DATA_OE), 32'd0);
        BUS_DATA_IN = 16'hDEAD;
        pulse(0, 0, 1, 0);                      // stray DTACK in S3
        chk("rd_s3_stray_dtack", 32'(RESP_RDATA), 32'd0);
        rise();
        chk("rd_s4_as_n", 32'(BUS_AS_n), 32'd0);
        BUS_DATA_IN = 16'hBEEF;
        pulse(0, 0, 1, 0);
        chk("rd_s5_latched", 32'(RESP_RDATA), 32'hBEEF);
        BUS_DATA_IN = 16'h0000;
        step();
        pulse(0, 0, 0, 1);
        chk("rd_s6_as_n", 32'(BUS_AS_n), 32'd0);
        fall();
        chk("rd_s7_released", 32'({BUS_AS_n, BUS_UDS_n, BUS_LDS_n}), 32'h7);
        rise();
        chk("rd_done_valid", 32'(RESP_VALID), 32'd1);
        chk("rd_done_ready", 32'(REQ_READY), 32'd0);
        step();
        chk("rd_after_valid", 32'(RESP_VALID), 32'd0);
        chk("rd_after_ready", 32'(REQ_READY), 32'd1);

        // Byte write, LDS only, data 0x00A5
        expect_resp(1'b0, 16'h0000, 1'b0);
        do_req(1'b0, 1'b0, 1'b1, 23'h000400, 16'h00A5);
        rise(); fall(); rise();
        chk("wr_s2_as_rw", 32'({BUS_AS_n, BUS_RW}), 32'h0);
        chk("wr_s2_ds", 32'({BUS_UDS_n, BUS_LDS_n}), 32'h3);
        fall();
        chk("wr_s3_oe", 32'(BUS_DATA_OE), 32'd1);
        chk("wr_s3_dout", 32'(BUS_DATA_OUT), 32'h00A5);
        chk("wr_s3_lds_n", 32'(BUS_LDS_n), 32'd1);
        rise();
        chk("wr_s4_ds", 32'({BUS_UDS_n, BUS_LDS_n}), 32'h2);
        pulse(0, 0, 1, 0); step(); pulse(0, 0, 0, 1);
        chk("wr_s6_ds_rw", 32'({BUS_UDS_n, BUS_LDS_n, BUS_RW}), 32'h4);
        fall();
        chk("wr_s7_ds", 32'({BUS_UDS_n, BUS_LDS_n}), 32'h3);
        chk("wr_s7_oe_rw", 32'({BUS_DATA_OE, BUS_RW}), 32'h2);
        rise();
        chk("wr_idle_oe_rw", 32'({BUS_DATA_OE, BUS_RW}), 32'h1);

        // No DTACK: timeout after the 4th falling edge in S4
        expect_resp(1'b1, 16'hFFFF, 1'b1);
        do_req(1'b1, 1'b1, 1'b1, 23'h000010, 16'h0000);
        to_s4();
        fall(); fall(); fall();
        chk("to_3rd_as_n", 32'(BUS_AS_n), 32'd0);
        fall();                                  // 4th: S4 -> S6
        rise();                                  // ignored in S6
        chk("to_s6_as_n", 32'(BUS_AS_n), 32'd0);
        fall();
        chk("to_s7_released", 32'({BUS_AS_n, BUS_UDS_n, BUS_LDS_n}), 32'h7);
        rise();
        chk("to_done_valid", 32'(RESP_VALID), 32'd1);

        // Reset in S4 of a write aborts with no response
        do_req(1'b0, 1'b1, 1'b1, 23'h000020, 16'h5555);
        to_s4();
        chk("rs_s4_oe", 32'(BUS_DATA_OE), 32'd1);
        RESET = 1;
        step();
        chk("rs_strobes", 32'({BUS_AS_n, BUS_UDS_n, BUS_LDS_n, BUS_RW}), 32'hF);
        chk("rs_oe", 32'(BUS_DATA_OE), 32'd0);
        chk("rs_valid", 32'(RESP_VALID), 32'd0);
        chk("rs_ready", 32'(REQ_READY), 32'd0);
        step();
        RESET = 0;
        step();
        expect_resp(1'b0, 16'h1234, 1'b1);
        do_req(1'b1, 1'b1, 1'b0, 23'h7FFFFF, 16'h0000);
        rise();
        chk("rs_new_addr", 32'(BUS_ADDR), 32'h7FFFFF);
        fall(); rise();
        chk("rs_new_ds", 32'({BUS_UDS_n, BUS_LDS_n}), 32'h1);
        fall(); rise();
        finish_dtack(16'h1234);
        chk("rs_new_valid", 32'(RESP_VALID), 32'd1);

        // Empty strobes: immediate error response, no bus cycle
        expect_resp(1'b1, 16'h0000, 1'b0);
        do_req(1'b1, 1'b0, 1'b0, 23'h000030, 16'h0000);
        chk("es_valid", 32'(RESP_VALID), 32'd1);
        chk("es_err", 32'(RESP_ERR), 32'd1);
        step();
        chk("es_valid_gone", 32'(RESP_VALID), 32'd0);
        chk("es_ready", 32'(REQ_READY), 32'd1);
        rise(); fall(); rise();
        chk("es_as_n", 32'(BUS_AS_n), 32'd1);

        // DTACK coincident with the final timeout edge: DTACK wins
        expect_resp(1'b0, 16'h5A5A, 1'b1);
        do_req(1'b1, 1'b1, 1'b1, 23'h000040, 16'h0000);
        to_s4();
        fall(); fall(); fall();
        BUS_DATA_IN = 16'h5A5A;
        pulse(0, 1, 1, 0);
        BUS_DATA_IN = 16'h0000;
        chk("co_latched", 32'(RESP_RDATA), 32'h5A5A);
        step();
        pulse(0, 0, 0, 1);
        fall();
        rise();
        chk("co_done_valid", 32'(RESP_VALID), 32'd1);

        repeat (4) step();
        chk("resp_count", 32'(resp_cnt), 32'(exp_cnt));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m68k_bus_cycle.md
M68K_BUS_CYCLE -- requirements
Module: m68k_bus_cycle

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: number of MCCLK_FALLING pulses spent in S4 before the cycle aborts with an error.
REQ-002 SYSCLK  in  1  system clock; all registers update on its rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 MCCLK_RISING  in  1  one-SYSCLK pulse per 68000 clock rising edge, from ClockSync.
REQ-005 MCCLK_FALLING  in  1  one-SYSCLK pulse per 68000 clock falling edge, from ClockSync.
REQ-006 DTACK_LATCH  in  1  pulse marking the read-data sample point after DTACK, from ClockSync.
REQ-007 DTACK_AFTER_LATCH  in  1  pulse two SYSCLK after DTACK_LATCH, from ClockSync.
REQ-008 REQ_VALID  in  1  host request valid.
REQ-009 REQ_READY  out  1  high only in IDLE.
REQ-010 REQ_RW  in  1  1 = read, 0 = write.
REQ-011 REQ_UDS, REQ_LDS  in  1 each  active-high byte enables.
REQ-012 REQ_ADDR  in  23  word address A23..A1.
REQ-013 REQ_WDATA  in  16  write data.
REQ-014 RESP_VALID  out  1  one-cycle completion pulse; no backpressure.
REQ-015 RESP_ERR  out  1  qualifies RESP_VALID: timeout or empty strobe.
REQ-016 RESP_RDATA  out  16  read data; held until the next response.
REQ-017 BUS_DATA_IN  in  16  sampled 68000 data bus.
REQ-018 BUS_ADDR  out  23  address bus.
REQ-019 BUS_DATA_OUT  out  16  write data bus.
REQ-020 BUS_DATA_OE  out  1  data bus drive enable.
REQ-021 BUS_AS_n, BUS_UDS_n, BUS_LDS_n, BUS_RW  out  1 each  68000 bus strobes (active low) and R/W.

Function
REQ-022 A handshake SHALL occur when REQ_VALID and REQ_READY are both high.
- All request fields are captured on that cycle.
- The FSM moves to ARMED.
REQ-023 ARMED: on MCCLK_RISING the FSM SHALL enter S0 and drive BUS_ADDR from the captured address; BUS_RW = REQ_RW.
REQ-024 S0: on MCCLK_FALLING the FSM SHALL enter S1.
REQ-025 S1: on MCCLK_RISING the FSM SHALL enter S2.
- BUS_AS_n = 0.
- Read: UDS_n/LDS_n asserted per enables.
- Write: BUS_RW = 0.
REQ-026 S2: on MCCLK_FALLING the FSM SHALL enter S3; write: BUS_DATA_OE = 1 and BUS_DATA_OUT = captured data.
REQ-027 S3: on MCCLK_RISING the FSM SHALL enter S4; write: UDS_n/LDS_n asserted per enables.
REQ-028 S4, DTACK_LATCH: the FSM SHALL enter S5; read: RESP_RDATA <= BUS_DATA_IN on that cycle.
REQ-029 S5: on DTACK_AFTER_LATCH the FSM SHALL enter S6.
REQ-030 S6: on MCCLK_FALLING the FSM SHALL enter S7 and deassert AS_n, UDS_n and LDS_n (all = 1).
REQ-031 S7: on MCCLK_RISING the FSM SHALL return to IDLE.
- BUS_DATA_OE = 0, BUS_RW = 1.
- RESP_VALID pulses for one cycle with RESP_ERR = 0.
REQ-032 Pulses not expected by the current state SHALL be ignored, including DTACK pulses outside S4/S5 and edges in IDLE.
REQ-033 Timeout: the counter is cleared on entering S4 and increments on each MCCLK_FALLING in S4.
- When it reaches TIMEOUT_CYCLES before DTACK_LATCH, the FSM SHALL enter S6 with an error flag set.
- The completion then has RESP_ERR = 1 and RESP_RDATA = 16'hFFFF.
REQ-034 If DTACK_LATCH and the final timeout MCCLK_FALLING coincide, DTACK SHALL win (normal completion).
REQ-035 A request with REQ_UDS = REQ_LDS = 0 SHALL NOT start a bus cycle.
- RESP_VALID and RESP_ERR pulse in the cycle after the handshake.
- The FSM stays in IDLE.
REQ-036 REQ_READY SHALL be low from the handshake cycle until the cycle after RESP_VALID; back-to-back requests are therefore separated by at least one IDLE cycle.

Reset
REQ-037 While RESET is high, the block SHALL hold these values; they apply on the first clock after RESET asserts, including mid-cycle:
- FSM = IDLE, any in-flight cycle aborted with no response.
- REQ_READY = 0 during reset, 1 after release.
- RESP_VALID = 0, RESP_ERR = 0, RESP_RDATA = 0.
- BUS_AS_n = BUS_UDS_n = BUS_LDS_n = 1, BUS_RW = 1, BUS_DATA_OE = 0.
- BUS_ADDR = 0, BUS_DATA_OUT = 0, timeout counter = 0.

Structure
REQ-038 The state encoding (IDLE, ARMED, S0..S7) and the response error data value (16'hFFFF) SHALL live in shared package m68k_bus_pkg.
REQ-039 The block SHALL be a single module with the timeout counter inline; no sub-module is required.

Verification
REQ-040 Word read, addr 0x123456>>1, BUS_DATA_IN = 0xBEEF, DTACK_LATCH in S4 -> RESP_VALID with RESP_RDATA = 0xBEEF, RESP_ERR = 0; AS_n low from S2 to S7.
REQ-041 Byte write (LDS only), data 0x00A5 -> LDS_n low from S4 to S7, UDS_n high throughout, BUS_DATA_OE high from S3 to IDLE, RW low from S2 to S7.
REQ-042 No DTACK with TIMEOUT_CYCLES = 4 -> after the 4th MCCLK_FALLING in S4, strobes release; RESP_ERR = 1, RESP_RDATA = 0xFFFF.
REQ-043 RESET asserted in S4 of a write -> next cycle all strobes = 1, OE = 0, no RESP_VALID; a new request after release completes normally.
REQ-044 UDS = LDS = 0 request -> RESP_VALID and RESP_ERR pulse one cycle after the handshake; AS_n never asserts.
REQ-045 DTACK_LATCH coincident with the final timeout edge -> RESP_ERR = 0 and the data is latched.
